// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per clock, optionally followed by GAP_CYCLES idle cycles.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int              CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam bit              HasGap  = (GAP_CYCLES > 0);
  localparam logic [3:0]      GapLast = HasGap ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CntW-1:0]  bitCnt_q, bitCnt_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic             lastBit;
  logic             accept;

  assign lastBit = (state_q == SHIFT) && (bitCnt_q == LastBit);
  assign accept  = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      gapCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      gapCnt_q   <= gapCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    gapCnt_d   = '0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (lastBit) begin
          if (accept)      state_d = SHIFT;
          else if (HasGap) state_d = GAP;
          else             state_d = IDLE;
        end
      end
      GAP: begin
        if (gapCnt_q == GapLast) state_d = IDLE;
        else                     gapCnt_d = gapCnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // A new word overrides the shift so back-to-back words leave no bubble.
    if (accept) begin
      shiftReg_d = data;
      bitCnt_d   = '0;
    end else if (state_q == SHIFT) begin
      shiftReg_d = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shiftReg_q[WIDTH-1:1]};
      bitCnt_d   = lastBit ? '0 : bitCnt_q + 1'b1;
    end
  end

  always_comb begin
    ser_valid  = (state_q == SHIFT);
    ser_out    = ser_valid & (MSB_FIRST ? shiftReg_q[WIDTH-1] : shiftReg_q[0]);
    word_done  = lastBit;
    busy       = (state_q != IDLE);
    load_ready = rst_n & ((state_q == IDLE) | (lastBit & ~HasGap));
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances cover MSB-first, LSB-first
// and gapped configurations, each driven and checked through a shared output mux.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lvA, lvB, lvC;
  logic [W-1:0] dA, dB, dC;
  logic         rdyA, outA, valA, doneA, busyA;
  logic         rdyB, outB, valB, doneB, busyB;
  logic         rdyC, outC, valC, doneC, busyC;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dutMsb (
    .clk(clk), .rst_n(rst_n), .load_valid(lvA), .data(dA), .load_ready(rdyA),
    .ser_out(outA), .ser_valid(valA), .word_done(doneA), .busy(busyA));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .load_valid(lvB), .data(dB), .load_ready(rdyB),
    .ser_out(outB), .ser_valid(valB), .word_done(doneB), .busy(busyB));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dutGap (
    .clk(clk), .rst_n(rst_n), .load_valid(lvC), .data(dC), .load_ready(rdyC),
    .ser_out(outC), .ser_valid(valC), .word_done(doneC), .busy(busyC));

  int   sel;
  logic oRdy, oOut, oVal, oDone, oBusy;

  always_comb begin
    case (sel)
      1:       {oRdy, oOut, oVal, oDone, oBusy} = {rdyB, outB, valB, doneB, busyB};
      2:       {oRdy, oOut, oVal, oDone, oBusy} = {rdyC, outC, valC, doneC, busyC};
      default: {oRdy, oOut, oVal, oDone, oBusy} = {rdyA, outA, valA, doneA, busyA};
    endcase
  end

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic selectDut(input int s);
    sel = s;
    #1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [W-1:0] d);
    case (sel)
      1:       begin lvB = lv; dB = d; end
      2:       begin lvC = lv; dC = d; end
      default: begin lvA = lv; dA = d; end
    endcase
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic eOut, input logic eVal,
                            input logic eDone, input logic eRdy, input logic eBusy);
    checkOutput({tag, " ser_out"},    32'(oOut),  32'(eOut));
    checkOutput({tag, " ser_valid"},  32'(oVal),  32'(eVal));
    checkOutput({tag, " word_done"},  32'(oDone), 32'(eDone));
    checkOutput({tag, " load_ready"}, 32'(oRdy),  32'(eRdy));
    checkOutput({tag, " busy"},       32'(oBusy), 32'(eBusy));
  endtask

  // Checks the eight bit cycles following an acceptance; the next input is
  // driven right after the first bit so the caller can queue or withdraw.
  task automatic streamWord(input string tag, input logic [W-1:0] w, input bit msb,
                            input bit rdyAtLast, input logic nextLv,
                            input logic [W-1:0] nextData);
    logic expBit;
    for (int k = 1; k <= W; k++) begin
      stepCycle();
      expBit = msb ? w[W-k] : w[k-1];
      checkCycle($sformatf("%s b%0d", tag, k), expBit, 1'b1, (k == W),
                 (k == W) && rdyAtLast, 1'b1);
      if (k == 1) applyStimulus(nextLv, nextData);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    sel   = 0;
    rst_n = 1'b0;
    lvA = 1'b0; lvB = 1'b0; lvC = 1'b0;
    dA  = '0;   dB  = '0;   dC  = '0;

    #2;
    checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkCycle("post-reset A", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    selectDut(1);
    checkCycle("post-reset B", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    selectDut(2);
    checkCycle("post-reset C", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    selectDut(0);
    applyStimulus(1'b1, 8'hA5);
    streamWord("msbA5", 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkCycle("msbA5 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    selectDut(1);
    applyStimulus(1'b1, 8'h0D);
    streamWord("lsb0D", 8'h0D, 1'b0, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkCycle("lsb0D idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    selectDut(0);
    applyStimulus(1'b1, 8'hB6);
    streamWord("b2bB6", 8'hB6, 1'b1, 1'b1, 1'b1, 8'h5A);
    streamWord("b2b5A", 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkCycle("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    selectDut(2);
    applyStimulus(1'b1, 8'hC3);
    streamWord("gapC3", 8'hC3, 1'b1, 1'b0, 1'b1, 8'h81);
    for (int g = 1; g <= 2; g++) begin
      stepCycle();
      checkCycle($sformatf("gap1 g%0d", g), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    stepCycle();
    checkCycle("gap1 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    streamWord("gap81", 8'h81, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int g = 1; g <= 2; g++) begin
      stepCycle();
      checkCycle($sformatf("gap2 g%0d", g), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    stepCycle();
    checkCycle("gap2 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Data churns with load_valid high while busy; only the last-bit cycle may accept.
    selectDut(0);
    w = 8'h3C;
    applyStimulus(1'b1, w);
    for (int k = 1; k <= W; k++) begin
      stepCycle();
      checkCycle($sformatf("hold3C b%0d", k), w[W-k], 1'b1, (k == W), (k == W), 1'b1);
      if (k < W) applyStimulus(1'b1, 8'(k * 37) ^ 8'hFF);
      else       applyStimulus(1'b0, 8'h00);
    end
    stepCycle();
    checkCycle("hold3C idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'hFF);
    for (int k = 1; k <= 3; k++) begin
      stepCycle();
      checkCycle($sformatf("abortFF b%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 1) applyStimulus(1'b0, 8'h00);
    end
    rst_n = 1'b0;
    #1;
    checkCycle("abort async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkCycle("abort held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkCycle("abort release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h80);
    streamWord("after80", 8'h80, 1'b1, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkCycle("after80 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
REQ-003 Parameter GAP_CYCLES, default 0, sets the number of idle cycles inserted after each word (legal range 0..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  upstream asserts when data holds a word to send.
REQ-007 data  input  WIDTH  parallel word; sampled only on acceptance.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 ser_out  output  1  serial bit stream, fed directly to the seq_det serial input.
REQ-010 ser_valid  output  1  high while ser_out carries a word bit.
REQ-011 word_done  output  1  one-cycle pulse coincident with the last bit of a word.
REQ-012 busy  output  1  high in the SHIFT and GAP states.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-014 Acceptance SHALL occur on a rising edge where load_valid and load_ready are both 1.
REQ-015 On acceptance, data SHALL be captured into the shift register, the bit counter SHALL be cleared, and the state SHALL become SHIFT.
REQ-016 The first bit SHALL appear on ser_out, with ser_valid=1, in the cycle immediately after acceptance (latency 1).
REQ-017 In SHIFT, one bit SHALL be presented per cycle in the order set by MSB_FIRST, and the counter SHALL increment 0..WIDTH-1.
REQ-018 word_done SHALL be 1 only in the cycle where the counter equals WIDTH-1.
REQ-019 load_ready SHALL be 1 in IDLE; in SHIFT it SHALL be 1 only in the last-bit cycle, and only when GAP_CYCLES=0; it SHALL be 0 in GAP.
REQ-020 Acceptance in the last-bit cycle (GAP_CYCLES=0) SHALL continue SHIFT with the new word, leaving no bubble in ser_valid.
REQ-021 After the last bit with no new acceptance: if GAP_CYCLES>0 the state SHALL be GAP; otherwise it SHALL be IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, with ser_out=0 and ser_valid=0, then return to IDLE.
REQ-023 In IDLE, ser_out SHALL be 0 and ser_valid SHALL be 0.
REQ-024 Changes on data or load_valid while load_ready=0 SHALL have no effect on state or outputs.
REQ-025 The bit counter SHALL be sized ceil(log2(WIDTH)) bits and SHALL never exceed WIDTH-1.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 immediately (asynchronously), the FSM SHALL be in IDLE, and the shift register and counters SHALL be cleared.
REQ-027 Reset mid-word SHALL abort the word: no word_done, and no residual bits after release.
REQ-028 On the first rising edge after rst_n deasserts, load_ready SHALL be 1.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance, ser_valid=1 throughout, word_done on cycle 8 only.
REQ-030 MSB_FIRST=0, accept 8'h0D -> ser_out 1,0,1,1,0,0,0,0, then IDLE with ser_out=0 and ser_valid=0.
REQ-031 GAP_CYCLES=0, load_valid held with 8'hB6 then 8'h5A -> 16 contiguous valid bits 1011011001011010, two word_done pulses 8 cycles apart.
REQ-032 GAP_CYCLES=2, two words queued -> ser_valid=0 and load_ready=0 for 2 cycles between words; second word starts 1 cycle after load_ready returns to 1.
REQ-033 rst_n driven low after bit 3 of 8'hFF -> all outputs 0 at once with no word_done; after release, accept 8'h80 -> ser_out 1,0,0,0,0,0,0,0.
REQ-034 Toggle data while busy=1 with load_valid=1 -> output stream matches the originally accepted word exactly.
